hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline controller that drives the WEN/flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Takes hazard sources from the register outputs and the caches: load-use, data-memory wait, instruction-fetch miss, taken branch (resolved in MEM), jump (resolved in ID) and halt.
- Sequences halt draining.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction cache hit for current PC.
dhit  in  1  data cache hit/complete for the EX/MEM access.
idex_MemRead  in  1  ID/EX M_MemRead_out.
idex_rt  in  5  ID/EX rt_out (load destination).
ifid_rs  in  5  rs field of IF/ID instruction_out.
ifid_rt  in  5  rt field of IF/ID instruction_out.
exmem_dREN  in  1  EX/MEM dREN_out.
exmem_dWEN  in  1  EX/MEM M_MemWrite_out.
branch_taken  in  1  branch in EX/MEM resolved taken.
jump_id  in  1  jump/jr/jal decoded in ID.
exmem_halt  in  1  EX/MEM halt_out.
pc_WEN  out  1  PC register load enable.
ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  register write enables.
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble on the next write.
halted  out  1  sticky halt indication.
stall_cnt  out  CNT_W  cycles in RUN with pc_WEN=0.
flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset → RUN.
- Outputs are combinational from state and inputs. Counters are registered.
- While nRST=0:
  - all WEN/flush outputs = 0, pc_WEN = 0, halted = 0.
  - counters = 0, state = RUN.
  - Reset mid-DRAIN or in HALTED returns to RUN immediately.
- Derived signals:
  - dwait = (exmem_dREN | exmem_dWEN) & ~dhit.
  - loaduse = idex_MemRead & idex_rt≠0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- RUN priority, first match wins. Unlisted outputs: WEN=1, flush=0.
  1. dwait: pc_WEN=0; ifid/idex/exmem WEN=0; memwb_WEN=1, memwb_flush=1 (bubble, no duplicate writeback).
  2. exmem_halt: pc_WEN=0; ifid_flush, idex_flush = 1; exmem_flush = 1 (halt passes into MEM/WB via its in-flight write; EX/MEM then holds a bubble). Next state DRAIN.
  3. branch_taken: pc_WEN=1 (loads target regardless of ihit); ifid/idex/exmem flush = 1; flush_cnt += 1.
  4. loaduse: pc_WEN=0; ifid_WEN=0 (hold); idex_flush=1. Exactly one bubble per load-use pair.
  5. jump_id: pc_WEN=1; ifid_flush=1.
  6. ~ihit: pc_WEN=0; ifid_flush=1.
  7. otherwise: pc_WEN=1, all WEN=1, no flush.
- DRAIN (one cycle):
  - pc_WEN=0; ifid/idex/exmem WEN=0; memwb_WEN=1 with flush=0 (halt commits).
  - Next state HALTED.
  - A dwait cannot be present, since EX/MEM holds a bubble.
- HALTED: all WEN=0, all flush=0, pc_WEN=0, halted=1. Left only by nRST.
- stall_cnt:
  - +1 per cycle with state==RUN & pc_WEN==0 (dwait, halt-entry, loaduse, ihit-miss cycles).
  - Saturates at 2^CNT_W−1. No wrap.
- flush_cnt: +1 per branch_taken flush cycle. Saturates likewise.
- Simultaneous events:
  - branch_taken with dwait: dwait wins, and the branch resolves when dwait clears.
  - branch_taken with loaduse: branch wins, and no idex_flush is double-counted.
  - branch_taken with exmem_halt: halt wins. Halt and branch cannot coexist in EX/MEM; halt is checked first.

Test Plan:
- Reset: nRST=0 with all inputs=1 → all outputs 0, counters 0. Release with ihit=1 and no hazards → pc_WEN=1 and all WEN=1 on the first cycle.
- Load-use: idex_MemRead=1, idex_rt=5, ifid_rs=5, ihit=1 → one cycle of pc_WEN=0, ifid_WEN=0, idex_flush=1; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- dwait: exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles of pc/ifid/idex/exmem WEN=0 with memwb_flush=1, then normal; stall_cnt=3.
- Branch: branch_taken=1 together with loaduse and ihit=0 → pc_WEN=1, ifid/idex/exmem flush=1, flush_cnt=1, stall_cnt unchanged.
- Halt: exmem_halt=1 → cycle0 flushes with pc_WEN=0; cycle1 DRAIN with memwb_WEN=1; cycle2+ halted=1, all WEN=0. Pulse nRST → RUN, halted=0.
- Saturation: CNT_W=2, ihit=0 for 5 cycles → stall_cnt sticks at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register enables/flushes, PC enable,
// halt drain sequencing and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             exmem_halt,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, nxt;
  logic   dwait;
  logic   loaduse;
  logic   stall_inc;
  logic   flush_inc;

  assign dwait = (exmem_dREN | exmem_dWEN) & ~dhit;

  assign loaduse = idex_MemRead
                 & (idex_rt != 5'd0)
                 & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    pc_WEN      = 1'b0;
    ifid_WEN    = 1'b0;
    idex_WEN    = 1'b0;
    exmem_WEN   = 1'b0;
    memwb_WEN   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    nxt         = state;
    if (nRST) begin
      unique case (state)
        RUN: begin
          pc_WEN    = 1'b1;
          ifid_WEN  = 1'b1;
          idex_WEN  = 1'b1;
          exmem_WEN = 1'b1;
          memwb_WEN = 1'b1;
          if (dwait) begin
            // retire a bubble so the stalled MEM op is not written back twice
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_flush = 1'b1;
          end else if (exmem_halt) begin
            pc_WEN      = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            nxt         = DRAIN;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (loaduse) begin
            pc_WEN     = 1'b0;
            ifid_WEN   = 1'b0;
            idex_flush = 1'b1;
          end else if (jump_id) begin
            ifid_flush = 1'b1;
          end else if (!ihit) begin
            pc_WEN     = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          memwb_WEN = 1'b1;
          nxt       = HALTED;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: nxt = RUN;
      endcase
    end
  end

  assign stall_inc = (state == RUN) & ~pc_WEN;
  assign flush_inc = (state == RUN) & ~dwait
                   & ~exmem_halt & branch_taken;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt;
      if (stall_inc && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl, with a 2-bit counter
// instance alongside for saturation.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, idex_MemRead;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       exmem_dREN, exmem_dWEN;
  logic       branch_taken, jump_id, exmem_halt;

  logic        pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        halted;
  logic [31:0] stall_cnt, flush_cnt;

  logic       s_pc, s_ifw, s_idw, s_exw, s_mww;
  logic       s_iff, s_idf, s_exf, s_mwf, s_h;
  logic [1:0] s_stall, s_flush;

  int n_chk  = 0;
  int n_fail = 0;

  // ctl = {pc, WEN ifid..memwb, flush ifid..memwb, halted}
  localparam logic [9:0] C_RST   = 10'b0_0000_0000_0;
  localparam logic [9:0] C_IDLE  = 10'b1_1111_0000_0;
  localparam logic [9:0] C_LU    = 10'b0_0111_0100_0;
  localparam logic [9:0] C_DW    = 10'b0_0001_0001_0;
  localparam logic [9:0] C_BR    = 10'b1_1111_1110_0;
  localparam logic [9:0] C_HALT  = 10'b0_1111_1110_0;
  localparam logic [9:0] C_DRAIN = 10'b0_0001_0000_0;
  localparam logic [9:0] C_HLTD  = 10'b0_0000_0000_1;
  localparam logic [9:0] C_JMP   = 10'b1_1111_1000_0;
  localparam logic [9:0] C_MISS  = 10'b0_1111_1000_0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .branch_taken(branch_taken), .jump_id(jump_id),
    .exmem_halt(exmem_halt),
    .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
    .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .branch_taken(branch_taken), .jump_id(jump_id),
    .exmem_halt(exmem_halt),
    .pc_WEN(s_pc), .ifid_WEN(s_ifw), .idex_WEN(s_idw),
    .exmem_WEN(s_exw), .memwb_WEN(s_mww),
    .ifid_flush(s_iff), .idex_flush(s_idf),
    .exmem_flush(s_exf), .memwb_flush(s_mwf),
    .halted(s_h), .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  function automatic logic [9:0] ctl();
    return {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
            ifid_flush, idex_flush, exmem_flush, memwb_flush,
            halted};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ihit = 1'b1; dhit = 1'b1; idex_MemRead = 1'b0;
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    branch_taken = 1'b0; jump_id = 1'b0; exmem_halt = 1'b0;
  endtask

  // advance one clock; inputs change on the falling edge
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    ihit = 1'b1; dhit = 1'b1; idex_MemRead = 1'b1;
    idex_rt = 5'h1f; ifid_rs = 5'h1f; ifid_rt = 5'h1f;
    exmem_dREN = 1'b1; exmem_dWEN = 1'b1;
    branch_taken = 1'b1; jump_id = 1'b1; exmem_halt = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_ctl", ctl(), C_RST);
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    step();
    check("rst_ctl_hold", ctl(), C_RST);

    idle_in();
    nRST = 1'b1;
    #1 check("idle0", ctl(), C_IDLE);
    step();
    check("idle_stall", stall_cnt, 0);

    idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 check("lu_ctl", ctl(), C_LU);
    step();
    check("lu_stall", stall_cnt, 1);
    idle_in();
    idex_MemRead = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7;
    #1 check("lu_rt_ctl", ctl(), C_LU);
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1 check("lu_r0_ctl", ctl(), C_IDLE);
    step();
    check("lu_r0_stall", stall_cnt, 1);

    idle_in();
    exmem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("dw_ctl", ctl(), C_DW);
      step();
    end
    check("dw_stall", stall_cnt, 4);
    dhit = 1'b1;
    #1 check("dw_done", ctl(), C_IDLE);
    exmem_dREN = 1'b0; exmem_dWEN = 1'b1; dhit = 1'b0;
    #1 check("dw_store", ctl(), C_DW);
    step();
    check("dw_store_stall", stall_cnt, 5);

    idle_in();
    branch_taken = 1'b1; ihit = 1'b0;
    idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 check("br_ctl", ctl(), C_BR);
    step();
    check("br_flush", flush_cnt, 1);
    check("br_stall", stall_cnt, 5);

    idle_in();
    branch_taken = 1'b1; exmem_dREN = 1'b1; dhit = 1'b0;
    #1 check("br_dw_ctl", ctl(), C_DW);
    step();
    check("br_dw_flush", flush_cnt, 1);
    check("br_dw_stall", stall_cnt, 6);

    idle_in();
    jump_id = 1'b1; ihit = 1'b0;
    #1 check("jmp_ctl", ctl(), C_JMP);
    step();
    check("jmp_stall", stall_cnt, 6);
    idle_in();
    ihit = 1'b0;
    #1 check("miss_ctl", ctl(), C_MISS);
    step();
    check("miss_stall", stall_cnt, 7);

    idle_in();
    exmem_halt = 1'b1; branch_taken = 1'b1;
    #1 check("halt_ctl", ctl(), C_HALT);
    step();
    check("halt_stall", stall_cnt, 8);
    check("halt_flush", flush_cnt, 1);
    idle_in();
    #1 check("drain_ctl", ctl(), C_DRAIN);
    step();
    check("drain_stall", stall_cnt, 8);
    ihit = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("hltd_ctl", ctl(), C_HLTD);
      step();
    end
    check("hltd_stall", stall_cnt, 8);
    check("hltd_flush", flush_cnt, 1);

    idle_in();
    nRST = 1'b0;
    #1 check("rst2_ctl", ctl(), C_RST);
    check("rst2_stall", stall_cnt, 0);
    step();
    nRST = 1'b1;
    #1 check("rst2_run", ctl(), C_IDLE);

    ihit = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat32", stall_cnt, i);
      check("sat2", s_stall, (i > 3) ? 3 : i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
